// File: rtl/uart_tx_byte_if.sv
// uart_tx_byte_if: client-side request/flow-control bundle for the byte UART transmitter.
`default_nettype none

interface uart_tx_byte_if;
    logic       block;
    logic       send;
    logic [7:0] data;
    logic       busy;

    modport master (output block, send, data, input busy);
    modport slave  (input block, send, data, output busy);
endinterface

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ============================================================================
// Module   : uart_tx_byte
// Brief    : Single-byte 8N1 UART transmitter with host flow-control block.
//            Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_byte #(
    parameter int CLK_PER_BIT = 434
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_byte_if.slave bus,
    output logic          tx
);

    localparam int c_CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic [2:0]         w_idx_inc;
    logic [7:0]         r_data;
    logic [7:0]         w_data_nxt;
    logic               r_tx;
    logic               w_tx_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               w_cnt_last;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    assign w_idx_inc  = r_idx + 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // tx is registered: each branch loads the level of the bit that starts on this edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_tx_nxt    = r_tx;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (bus.send && !bus.block) begin
                    w_state_nxt = S_START;
                    w_data_nxt  = bus.data;
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 3'd0;
                    w_tx_nxt    = r_data[0];
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = ^r_data;
`else
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        w_tx_nxt  = r_data[w_idx_inc];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_STOP;
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_tx_nxt    = 1'b1;
            end
        endcase

        w_busy_nxt = bus.block | (w_state_nxt != S_IDLE);
    end

    assign tx       = r_tx;
    assign bus.busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_byte.sv
// tb_uart_tx_byte: scoreboard bench; a line monitor decodes frames and pops expected bytes.
`default_nettype none

module tb_uart_tx_byte;

    localparam int CPB = 434;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;
    localparam int P     = FRAME + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx;
    uart_tx_byte_if bus ();

    uart_tx_byte #(.CLK_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    always #10 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         frames = 0;
    int         cyc    = 0;
    bit         mon_en = 1'b1;
    logic [7:0] exp_q[$];
    int         start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Decodes each frame from the first low cycle by sampling mid-bit.
    initial begin : monitor
        logic [NB-1:0] bits;
        logic [7:0]    got;
        logic [7:0]    exp_b;
        forever begin
            @(negedge clk);
            if (mon_en && rst === 1'b1 && tx === 1'b0) begin
                start_q.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                bits[0] = tx;
                for (int b = 1; b < NB; b++) begin
                    repeat (CPB) @(negedge clk);
                    bits[b] = tx;
                end
                got = bits[8:1];
                frames++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame: got byte 0x%02h, no frame expected", got);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (got !== exp_b) begin
                        errors++;
                        $display("FAIL frame_data: got 0x%02h, expected 0x%02h", got, exp_b);
                    end
                end
                checks++;
                if (bits[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL start_bit: got %b, expected 0", bits[0]);
                end
                checks++;
                if (bits[NB-1] !== 1'b1) begin
                    errors++;
                    $display("FAIL stop_bit: got %b, expected 1", bits[NB-1]);
                end
`ifdef UART_TX_PARITY_EN
                checks++;
                if (bits[9] !== ^got) begin
                    errors++;
                    $display("FAIL parity_bit: got %b, expected %b", bits[9], ^got);
                end
`endif
                repeat (CPB - CPB / 2) @(negedge clk);
            end
        end
    end

    initial begin : watchdog
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst = 1'b0;
        bus.send  = 1'b1;
        bus.data  = 8'hFF;
        bus.block = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL reset_tx: cycle %0d got %b, expected 1", i, tx);
            end
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy: cycle %0d got %b, expected 0", i, bus.busy);
            end
        end
        bus.send = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || bus.busy !== 1'b0 || frames != 0) begin
            errors++;
            $display("FAIL post_reset_idle: tx=%b busy=%b frames=%0d, expected 1/0/0", tx, bus.busy, frames);
        end
    endtask

    task automatic test_block;
        int f0 = frames;
        int bad = 0;
        bus.block = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL block_to_busy: got %b, expected 1", bus.busy);
        end
        bus.send = 1'b1;
        bus.data = 8'h4F;
        @(negedge clk);
        bus.send = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL blocked_send: %0d cycles with tx!=1 or busy!=1, expected 0", bad);
        end
        bus.block = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL unblock_delay: busy got %b before edge, expected 1", bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL unblock_busy: got %b, expected 0", bus.busy);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (frames != f0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL blocked_no_frame: frames=%0d tx=%b, expected %0d/1", frames, tx, f0);
        end
    endtask

    task automatic test_basic;
        int f0 = frames;
        int n  = 0;
        bus.send = 1'b1;
        bus.data = 8'h4F;
        exp_q.push_back(8'h4F);
        @(negedge clk);
        bus.send = 1'b0;
        bus.data = 8'hFF;
        checks++;
        if (tx !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_latency: tx=%b busy=%b, expected 0/1", tx, bus.busy);
        end
        while (bus.busy === 1'b1 && n <= FRAME + 5) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != FRAME) begin
            errors++;
            $display("FAIL busy_length: got %0d cycles, expected %0d", n, FRAME);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (frames != f0 + 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_frame_count: frames=%0d pending=%0d, expected %0d/0", frames, exp_q.size(), f0 + 1);
        end
    endtask

    task automatic test_ignored;
        int f0 = frames;
        bus.send = 1'b1;
        bus.data = 8'h3C;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        bus.send = 1'b0;
        bus.data = 8'hFF;
        repeat (3 * CPB) @(negedge clk);
        bus.send = 1'b1;
        bus.data = 8'hA5;
        @(negedge clk);
        bus.send = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        checks++;
        if (frames != f0 + 1 || exp_q.size() != 0 || bus.busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL ignored_request: frames=%0d pending=%0d busy=%b tx=%b, expected %0d/0/0/1",
                     frames, exp_q.size(), bus.busy, tx, f0 + 1);
        end
    endtask

    task automatic test_back_to_back;
        int f0 = frames;
        start_q.delete();
        bus.send = 1'b1;
        bus.data = 8'h00;
        for (int i = 0; i < 3; i++) exp_q.push_back(8'h00);
        repeat (2 * P + 1) @(negedge clk);
        bus.send = 1'b0;
        repeat (FRAME + 5) @(negedge clk);
        checks++;
        if (frames != f0 + 3 || start_q.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: frames=%0d starts=%0d, expected %0d/3", frames, start_q.size(), f0 + 3);
        end
        if (start_q.size() == 3) begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (start_q[i] - start_q[i-1] != P) begin
                    errors++;
                    $display("FAIL b2b_gap: start spacing %0d cycles, expected %0d", start_q[i] - start_q[i-1], P);
                end
            end
        end
    endtask

    task automatic test_block_mid;
        int f0 = frames;
        int bad = 0;
        bus.send = 1'b1;
        bus.data = 8'hC3;
        exp_q.push_back(8'hC3);
        @(negedge clk);
        bus.send = 1'b0;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        bus.block = 1'b1;
        repeat (FRAME - (4 * CPB + CPB / 2)) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL block_mid_end: busy=%b tx=%b, expected 1/1", bus.busy, tx);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (frames != f0 + 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL block_mid_frame: frames=%0d pending=%0d, expected %0d/0", frames, exp_q.size(), f0 + 1);
        end
        bus.send = 1'b1;
        bus.data = 8'h11;
        @(negedge clk);
        bus.send = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL block_hold: %0d cycles with tx!=1 or busy!=1, expected 0", bad);
        end
        bus.block = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL block_release: busy got %b, expected 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        mon_en = 1'b0;
        bus.send = 1'b1;
        bus.data = 8'hA5;
        @(negedge clk);
        bus.send = 1'b0;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_bit3: tx got %b, expected 0", tx);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: tx=%b busy=%b, expected 1/0", tx, bus.busy);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_idle: %0d cycles not idle, expected 0", bad);
        end
        mon_en = 1'b1;
    endtask

    initial begin
        bus.send  = 1'b0;
        bus.data  = 8'h00;
        bus.block = 1'b0;
        test_reset();
        test_block();
        test_basic();
        test_ignored();
        test_back_to_back();
        test_block_mid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
